// File: rtl/jt12_op_wave_pkg.sv
// Shared constants and table generators for the FM operator waveform pipeline.
package jt12_op_wave_pkg;

    localparam int LATENCY    = 5;             // VIII -> XIII, in enabled cycles
    localparam int NUM_CH_DEF = 6;
    localparam int NUM_SLOTS  = 4 * NUM_CH_DEF;
    localparam int ROM_AW     = 8;
    localparam int ROM_DEPTH  = 256;
    localparam int LS_W       = 12;            // log-sine entry width
    localparam int EXP_W      = 10;            // exp entry width
    localparam int PH_W       = 10;
    localparam int EG_W       = 10;
    localparam int ATT_W      = 13;
    localparam int MAG_W      = 13;
    localparam int RES_W      = 14;
    localparam int FB_W       = 3;
    localparam int CH_W       = 3;

    localparam real PI = 3.14159265358979323846;

    // Sideband that rides along with each slot through the pipeline
    typedef struct packed {
        logic            sgn;
        logic            op1;
        logic [CH_W-1:0] ch;
    } slot_tag_t;

    // Quarter-wave log-sine: -log2(sin) in 4.8 fixed point, sampled at bin centres
    function automatic logic [LS_W-1:0] logsin_calc(input int i);
        real s;
        s = $sin((real'(i) + 0.5) / real'(ROM_DEPTH) * PI / 2.0);
        return LS_W'($rtoi(-$ln(s) / $ln(2.0) * 256.0 + 0.5));
    endfunction

    // Fractional part of 2^x as a 0.10 mantissa (implicit leading one added later)
    function automatic logic [EXP_W-1:0] exp_calc(input int j);
        return EXP_W'($rtoi(($pow(2.0, real'(j) / real'(ROM_DEPTH)) - 1.0) * 1024.0 + 0.5));
    endfunction

endpackage

// File: rtl/jt12_op_wave_if.sv
// Slot-rate bus between the phase/envelope generators and the operator.
interface jt12_op_wave_if;
    import jt12_op_wave_pkg::*;

    logic              clk_en;
    logic [PH_W-1:0]   phase_VIII;
    logic [PH_W-1:0]   pm_VIII;
    logic [FB_W-1:0]   fb_VIII;
    logic              op1_VIII;
    logic [CH_W-1:0]   ch_VIII;
    logic [EG_W-1:0]   eg_atten_IX;
    logic [RES_W-1:0]  op_result_XIII;

    modport master (
        output clk_en, phase_VIII, pm_VIII, fb_VIII, op1_VIII, ch_VIII, eg_atten_IX,
        input  op_result_XIII
    );

    modport slave (
        input  clk_en, phase_VIII, pm_VIII, fb_VIII, op1_VIII, ch_VIII, eg_atten_IX,
        output op_result_XIII
    );
endinterface

// File: rtl/jt12_logexp.sv
// Log-sine and exp lookup tables with registered read ports.
module jt12_logexp
    import jt12_op_wave_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ROM_AW-1:0] ls_addr,
    input  logic [ROM_AW-1:0] exp_addr,
    output logic [LS_W-1:0]   ls_q,
    output logic [EXP_W-1:0]  exp_q
);

    logic [LS_W-1:0]  ls_rom  [ROM_DEPTH];
    logic [EXP_W-1:0] exp_rom [ROM_DEPTH];
    logic [LS_W-1:0]  ls_d;
    logic [EXP_W-1:0] exp_d;

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        assign ls_rom[i]  = logsin_calc(i);
        assign exp_rom[i] = exp_calc(i);
    end

    // Table lookup feeding the output registers
    always_comb begin
        ls_d  = ls_rom[ls_addr];
        exp_d = exp_rom[exp_addr];
    end

    // Read registers advance with the slot clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_q  <= '0;
            exp_q <= '0;
        end else if (en) begin
            ls_q  <= ls_d;
            exp_q <= exp_d;
        end
    end

endmodule

// File: rtl/jt12_op_wave.sv
// FM operator: phase -> log-sine -> attenuation -> exp -> signed sample,
// five slot-rate stages (VIII..XIII) plus operator-1 self-feedback history.
module jt12_op_wave
    import jt12_op_wave_pkg::*;
#(
    parameter int num_ch = NUM_CH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    jt12_op_wave_if.slave bus
);

    localparam int VW = LATENCY - 1;   // valid bits for stages IX..XII

    // Pipeline state
    logic [VW-1:0]      vld_d, vld_q;
    logic [PH_W-2:0]    ph_ix_d, ph_ix_q;
    slot_tag_t          tag_ix_d, tag_ix_q, tag_x_d, tag_x_q;
    slot_tag_t          tag_xi_d, tag_xi_q, tag_xii_d, tag_xii_q;
    logic [EG_W-1:0]    eg_x_d, eg_x_q;
    logic [4:0]         shift_xi_d, shift_xi_q;
    logic [MAG_W-1:0]   mag_xii_d, mag_xii_q;
    logic [RES_W-1:0]   op_result_d, op_result_q;
    logic [RES_W-1:0]   prev1_d [num_ch];
    logic [RES_W-1:0]   prev1_q [num_ch];
    logic [RES_W-1:0]   prev2_d [num_ch];
    logic [RES_W-1:0]   prev2_q [num_ch];

    // Combinational intermediates
    logic [RES_W-1:0]   fb_p1, fb_p2;
    logic signed [14:0] fb_sum;
    logic [3:0]         fb_sh;
    logic [PH_W-1:0]    fb_term, ph_sum;
    logic [ROM_AW-1:0]  ls_addr, exp_addr;
    logic [LS_W-1:0]    ls_data;
    logic [EXP_W-1:0]   exp_data;
    logic [ATT_W-1:0]   att;
    logic [RES_W-1:0]   res;

    jt12_logexp u_logexp (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.clk_en),
        .ls_addr  (ls_addr),
        .exp_addr (exp_addr),
        .ls_q     (ls_data),
        .exp_q    (exp_data)
    );

    // Stage datapaths, next-state and feedback history update
    always_comb begin
        vld_d       = vld_q;
        ph_ix_d     = ph_ix_q;
        tag_ix_d    = tag_ix_q;
        tag_x_d     = tag_x_q;
        tag_xi_d    = tag_xi_q;
        tag_xii_d   = tag_xii_q;
        eg_x_d      = eg_x_q;
        shift_xi_d  = shift_xi_q;
        mag_xii_d   = mag_xii_q;
        op_result_d = op_result_q;
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;

        // VIII: history of this channel; out-of-range channels read zero
        fb_p1 = '0;
        fb_p2 = '0;
        for (int c = 0; c < num_ch; c++) begin
            if (int'(bus.ch_VIII) == c) begin
                fb_p1 = prev1_q[c];
                fb_p2 = prev2_q[c];
            end
        end
        fb_sum  = {fb_p1[RES_W-1], fb_p1} + {fb_p2[RES_W-1], fb_p2};
        fb_sh   = 4'd10 - {1'b0, bus.fb_VIII};
        fb_term = (bus.op1_VIII && bus.fb_VIII != '0) ? PH_W'(fb_sum >>> fb_sh) : '0;
        ph_sum  = bus.phase_VIII + bus.pm_VIII + fb_term;

        // IX: fold the second quarter back onto the table
        ls_addr = ph_ix_q[8] ? ~ph_ix_q[7:0] : ph_ix_q[7:0];

        // X: total attenuation in log domain; low byte selects the mantissa
        att      = {1'b0, ls_data} + {1'b0, eg_x_q, 2'b00};
        exp_addr = ~att[7:0];

        // XII: signed result; a zero magnitude stays zero when negated
        res = {1'b0, mag_xii_q};
        if (tag_xii_q.sgn) res = -res;

        if (bus.clk_en) begin
            vld_d     = {vld_q[VW-2:0], 1'b1};
            ph_ix_d   = ph_sum[PH_W-2:0];
            tag_ix_d  = '{sgn: ph_sum[PH_W-1], op1: bus.op1_VIII, ch: bus.ch_VIII};
            tag_x_d   = tag_ix_q;
            eg_x_d    = bus.eg_atten_IX;
            tag_xi_d  = tag_x_q;
            shift_xi_d = att[12:8];
            tag_xii_d = tag_xi_q;
            mag_xii_d = {1'b1, exp_data, 2'b00} >> shift_xi_q;
            op_result_d = vld_q[VW-1] ? res : '0;
            // Operator-1 results become the channel's feedback history
            if (vld_q[VW-1] && tag_xii_q.op1) begin
                for (int c = 0; c < num_ch; c++) begin
                    if (int'(tag_xii_q.ch) == c) begin
                        prev2_d[c] = prev1_q[c];
                        prev1_d[c] = res;
                    end
                end
            end
        end
    end

    // State registers; reset flushes in-flight slots and the history
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            ph_ix_q     <= '0;
            tag_ix_q    <= '0;
            tag_x_q     <= '0;
            tag_xi_q    <= '0;
            tag_xii_q   <= '0;
            eg_x_q      <= '0;
            shift_xi_q  <= '0;
            mag_xii_q   <= '0;
            op_result_q <= '0;
            prev1_q     <= '{default: '0};
            prev2_q     <= '{default: '0};
        end else begin
            vld_q       <= vld_d;
            ph_ix_q     <= ph_ix_d;
            tag_ix_q    <= tag_ix_d;
            tag_x_q     <= tag_x_d;
            tag_xi_q    <= tag_xi_d;
            tag_xii_q   <= tag_xii_d;
            eg_x_q      <= eg_x_d;
            shift_xi_q  <= shift_xi_d;
            mag_xii_q   <= mag_xii_d;
            op_result_q <= op_result_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
        end
    end

    assign bus.op_result_XIII = op_result_q;

endmodule

// File: tb/tb_jt12_op_wave.sv
// Bench for jt12_op_wave: directed slots and full frames against a
// table-driven model of the operator, with literal anchors.
module tb_jt12_op_wave;
    import jt12_op_wave_pkg::*;

    logic clk;
    logic rst;
    jt12_op_wave_if bus();

    jt12_op_wave #(.num_ch(NUM_CH_DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int exp_v;
        int lit;
        bit has_lit;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   ls_t [256];
    int   ex_t [256];
    int   m_p1 [8];
    int   m_p2 [8];
    exp_t q [$];
    int   slot_eg = 0;
    int   slot_lit = 0;
    bit   slot_has_lit = 0;
    int   prev_eg = 0;
    int   last_out = 0;
    bit   out_known = 0;
    int   out_idx = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s out#%0d actual=%0d expected=%0d", nm, out_idx, act, exp_v);
        end
    endtask

    // Operator output from a final phase and attenuation, straight from the table definitions
    function automatic int wave(input int ph, input int eg);
        int idx, att, sh, mag;
        idx = ph % 512;
        if (idx >= 256) idx = 511 - idx;
        att = ls_t[idx] + 4 * eg;
        sh  = att / 256;
        mag = (sh >= 13) ? 0 : (((1024 + ex_t[255 - (att % 256)]) * 4) >> sh);
        return (ph >= 512) ? -mag : mag;
    endfunction

    // Model and compare: one slot enters per enabled edge, leaves LATENCY edges later
    always @(posedge clk) begin
        exp_t e;
        int   ch, fbt, ph, sum;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 8; i++) begin m_p1[i] = 0; m_p2[i] = 0; end
            #1;
            chk("reset_out", int'($signed(bus.op_result_XIII)), 0);
            last_out  = 0;
            out_known = 1;
        end else if (bus.clk_en) begin
            ch  = int'(bus.ch_VIII);
            fbt = 0;
            if (bus.op1_VIII && bus.fb_VIII != 0) begin
                sum = m_p1[ch] + m_p2[ch];
                fbt = (sum >>> (10 - int'(bus.fb_VIII))) & 1023;
            end
            ph = (int'(bus.phase_VIII) + int'(bus.pm_VIII) + fbt) % 1024;
            e.exp_v   = wave(ph, slot_eg);
            e.lit     = slot_lit;
            e.has_lit = slot_has_lit;
            if (bus.op1_VIII && ch < NUM_CH_DEF) begin
                m_p2[ch] = m_p1[ch];
                m_p1[ch] = e.exp_v;
            end
            q.push_back(e);
            #1;
            if (q.size() == LATENCY) begin
                e = q.pop_front();
                chk("model", int'($signed(bus.op_result_XIII)), e.exp_v);
                if (e.has_lit) chk("literal", int'($signed(bus.op_result_XIII)), e.lit);
                last_out  = e.exp_v;
                out_known = 1;
                out_idx++;
            end else begin
                out_known = 0;
            end
        end else begin
            #1;
            if (out_known) chk("hold", int'($signed(bus.op_result_XIII)), last_out);
        end
    end

    // One slot at stage VIII; its attenuation is presented one slot later
    task automatic drive(input bit en, input int phase, input int pm, input int fb,
                         input bit op1, input int ch, input int eg,
                         input int lit, input bit has_lit);
        @(negedge clk);
        rst              = 1'b0;
        bus.clk_en       = en;
        bus.phase_VIII   = 10'(phase);
        bus.pm_VIII      = 10'(pm);
        bus.fb_VIII      = 3'(fb);
        bus.op1_VIII     = op1;
        bus.ch_VIII      = 3'(ch);
        bus.eg_atten_IX  = 10'(prev_eg);
        slot_eg          = eg;
        slot_lit         = lit;
        slot_has_lit     = has_lit;
        @(posedge clk);
        if (en) prev_eg = eg;
    endtask

    task automatic do_reset(input int n, input bit en);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst        = 1'b1;
            bus.clk_en = en;
            @(posedge clk);
        end
    endtask

    // Full frame: slot s is channel s%6, operator s/6; operator 1 uses feedback.
    // Channel 0 operator 1 is steered so its feedback lands on known phases.
    task automatic run_frame(input int f, input int nslots, input int stall_at);
        int ch0_ph [6];
        int ch0_lit [6];
        int ch, fb, ph, pm, eg;
        bit op1, has;
        ch0_ph  = '{'h100, 'h303, 'h100, 'h300, 'h155, 'h2e1};
        ch0_lit = '{8168, -8168, 8168, -8168, 0, 0};
        for (int s = 0; s < nslots; s++) begin
            if (s == stall_at)
                for (int k = 0; k < 3; k++) drive(0, 'h3aa, 'h155, 7, 1, 0, 777, 0, 0);
            ch  = s % NUM_CH_DEF;
            op1 = (s < NUM_CH_DEF);
            fb  = op1 ? ((ch == 2) ? 3 : 7) : 5;
            if (op1 && ch == 0) begin
                ph  = ch0_ph[f % 6];
                pm  = 0;
                eg  = 0;
                has = (f < 4);
                drive(1, ph, pm, fb, op1, ch, eg, ch0_lit[f % 6], has);
            end else begin
                ph = (s * 37 + f * 101 + ch * 3) % 1024;
                pm = op1 ? 0 : (s * 53 + f * 11) % 1024;
                eg = (s * 29 + f * 7) % 400;
                drive(1, ph, pm, fb, op1, ch, eg, 0, 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ls_t[i] = $rtoi(-$ln($sin((real'(i) + 0.5) / 256.0 * PI / 2.0)) / $ln(2.0) * 256.0 + 0.5);
            ex_t[i] = $rtoi(($pow(2.0, real'(i) / 256.0) - 1.0) * 1024.0 + 0.5);
        end
        rst             = 1'b1;
        bus.clk_en      = 1'b0;
        bus.phase_VIII  = '0;
        bus.pm_VIII     = '0;
        bus.fb_VIII     = '0;
        bus.op1_VIII    = 1'b0;
        bus.ch_VIII     = '0;
        bus.eg_atten_IX = '0;
        do_reset(2, 1'b1);
        do_reset(1, 1'b0);

        // Directed single slots, no feedback
        drive(1, 'h100, 0,     0, 0, 0, 0,    8168, 1);
        drive(1, 'h300, 0,     0, 0, 1, 0,   -8168, 1);
        drive(1, 'h0ff, 0,     0, 0, 2, 0,    8168, 1);
        drive(1, 'h123, 0,     0, 0, 3, 1023, 0,    1);
        drive(1, 'h2ab, 0,     7, 0, 4, 1023, 0,    1);
        drive(1, 'h080, 'h080, 7, 0, 5, 0,    8168, 1);
        drive(1, 'h3ff, 'h001, 0, 0, 0, 0,    0,    0);
        drive(1, 'h040, 0,     0, 0, 1, 100,  0,    0);
        drive(1, 'h1c0, 'h200, 0, 0, 2, 300,  0,    0);
        drive(1, 'h2f7, 'h013, 0, 0, 3, 511,  0,    0);

        // Feedback frames, with a three-cycle enable gap inside frame 2
        for (int f = 0; f < 6; f++) run_frame(f, NUM_SLOTS, (f == 2) ? 10 : -1);

        // Operator 1 with feedback level 0 ignores nonzero history
        drive(1, 'h100, 0, 0, 1, 0, 0,  8168, 1);
        drive(1, 'h2ab, 0, 0, 1, 1, 50, 0,    0);
        // Channels beyond the frame have no history
        drive(1, 'h100, 0, 7, 1, 6, 0,  8168, 1);
        drive(1, 'h100, 0, 7, 1, 7, 0,  8168, 1);
        drive(1, 'h300, 0, 7, 1, 7, 0, -8168, 1);

        // Reset mid-frame, then history must start from zero
        run_frame(6, 12, -1);
        do_reset(1, 1'b0);
        do_reset(1, 1'b1);
        run_frame(0, NUM_SLOTS, -1);
        run_frame(1, NUM_SLOTS, -1);
        for (int k = 0; k < LATENCY; k++) drive(1, k * 64, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt12_op_wave.md
JT12_OP_WAVE -- requirements
Module: jt12_op_wave

Interface
REQ-001 Parameter: num_ch, default 6, channels per time-multiplexed frame; 4*num_ch operator slots.
REQ-002 clk  in  1  single system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 clk_en  in  1  slot advance; all state updates only when high.
REQ-005 phase_VIII  in  10  operator phase from the phase generator, stage VIII of current slot.
REQ-006 pm_VIII  in  10  phase modulation from other operators, already algorithm-selected; 0 = none.
REQ-007 fb_VIII  in  3  self-feedback level of current channel; 0 = off.
REQ-008 op1_VIII  in  1  high when current slot is operator 1, the only feedback-capable operator.
REQ-009 ch_VIII  in  3  channel index 0..num_ch-1 of current slot.
REQ-010 eg_atten_IX  in  10  envelope attenuation, stage IX; 0 = loudest, 1023 = silent.
REQ-011 op_result_XIII  out  14  signed operator output, stage XIII.

Function
REQ-012 Stage VIII: ph = phase_VIII + pm_VIII + fbterm, modulo 1024.
REQ-013 fbterm is 0 unless op1_VIII=1 and fb_VIII!=0.
REQ-014 With feedback active, fbterm = low 10 bits of (prev1+prev2) arithmetically shifted right by 10-fb_VIII; sum taken 15-bit signed.
REQ-015 prev1/prev2 are the last two operator-1 results of channel ch_VIII.
REQ-016 Stage IX: sign = ph[9]; addr = ph[8] ? ~ph[7:0] : ph[7:0].
REQ-017 Log-sine ROM: 256x12, entry i = round(-log2(sin((i+0.5)/256*pi/2))*256).
REQ-018 Stage X: att = logsin + {eg_atten_IX,2'b00}; 13-bit unsigned, cannot overflow.
REQ-019 Stage XI: exp ROM 256x10, entry j = round((2^(j/256)-1)*1024), indexed by ~att[7:0].
REQ-020 Stage XI: shift = att[12:8].
REQ-021 Stage XII: mag = ({1'b1,exp,2'b00} >> shift), 13 bits; shift>=13 gives 0.
REQ-022 Stage XIII: op_result = sign ? -mag : mag; negative zero yields 0.
REQ-023 Latency: a slot presented at VIII appears at op_result_XIII exactly 5 clk_en-high cycles later.
REQ-024 Throughput: one slot per clk_en cycle; no stalls, no handshake.
REQ-025 sign, channel index and op1 flag travel with the slot through the pipeline.
REQ-026 Feedback store: 2 x 14-bit words per channel.
REQ-027 When a result with op1 flag set leaves stage XIII, prev2<=prev1 and prev1<=result for its channel.
REQ-028 Simultaneous store write and read of different channels is legal and independent.
REQ-029 Same-channel write/read collision cannot occur (24-slot spacing > 5-stage latency); no bypass required.
REQ-030 clk_en low: all pipeline registers and feedback store hold.
REQ-031 ch_VIII >= num_ch: feedback reads as 0 and no store write occurs.

Reset
REQ-032 While rst is high at a clk edge, all pipeline registers, op_result_XIII and the feedback store clear to 0, regardless of clk_en.
REQ-033 Reset mid-frame discards in-flight slots; the first valid output appears 5 enabled cycles after rst falls.

Structure
REQ-034 A shared package holds: pipeline latency (5), slot count, ROM depth/width constants and the result width (14).
REQ-035 The ROMs live in one sub-module, jt12_logexp, holding the log-sine and exp tables.
REQ-036 jt12_logexp exposes registered read ports only.
REQ-037 Pipeline control and the feedback store stay in jt12_op_wave.

Verification
REQ-038 phase_VIII=0x100, pm=0, eg=0, op1=0 -> op_result_XIII=+8168 after 5 enables.
REQ-039 phase_VIII=0x300, pm=0, eg=0 -> -8168; phase_VIII=0x0FF -> +8168.
REQ-040 Any phase, eg_atten_IX=1023 -> op_result_XIII=0.
REQ-041 op1=1, fb=0, preloaded nonzero history -> output identical to the op1=0 case.
REQ-042 op1=1, fb=7, full 24-slot frames -> prev1/prev2 update only on op1 slots of the matching channel; output matches a golden model each frame.
REQ-043 Toggle clk_en low 3 cycles mid-stream -> output held and sequence resumes unchanged.
REQ-044 Assert rst mid-frame -> outputs 0; feedback history cleared.
